// File: rtl/dsc_stream_decoder_pkg.sv
// Shared definitions for the DSC stream decoder: default datapath sizing and
// the decoder FSM state encoding.
package dsc_stream_decoder_pkg;

   localparam int unsigned SNG_WIDTH_DEF  = 10;
   localparam int unsigned NUM_INPUTS_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

endpackage

// File: rtl/dsc_stream_decoder_frame_counter.sv
// Bit-position counter for one frame: wraps naturally at 2^WIDTH-1 and flags
// the terminal position so the caller can close the frame.
module frame_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] cnt,
   output logic             tc
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = &cnt_q;

endmodule

// File: rtl/dsc_stream_decoder.sv
// Framed stochastic-to-binary decoder: counts ones over 2^OUT_WIDTH accepted
// bits and offers the saturated count on a valid/ready result port.
module dsc_stream_decoder
   import dsc_stream_decoder_pkg::*;
#(
   parameter int unsigned SNG_WIDTH  = SNG_WIDTH_DEF,
   parameter int unsigned NUM_INPUTS = NUM_INPUTS_DEF,
   parameter int unsigned OUT_WIDTH  = NUM_INPUTS * SNG_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 start,
   input  logic                 cont,
   input  logic                 sn_in,
   input  logic                 sn_valid,
   output logic                 sn_ready,
   output logic [OUT_WIDTH-1:0] z,
   output logic                 z_valid,
   input  logic                 z_ready,
   output logic                 z_sat,
   output logic                 busy
);

   state_e                 state_q, state_d;
   logic [OUT_WIDTH:0]     ones_q, ones_d;
   logic [OUT_WIDTH-1:0]   z_q, z_d;
   logic                   z_valid_q, z_valid_d;
   logic                   z_sat_q, z_sat_d;

   logic [OUT_WIDTH-1:0]   bit_cnt;
   logic                   bit_tc;
   logic                   accept, restart, count_bit, frame_done;
   logic                   z_free, release_full, load;
   logic [OUT_WIDTH:0]     ones_inc, load_val;

   // start restarts a frame from IDLE or COUNT; a stalled frame in FULL ignores it.
   assign accept       = sn_valid & sn_ready & en;
   assign restart      = start & en & (state_q != ST_FULL);
   assign count_bit    = accept & ~restart;
   assign frame_done   = count_bit & bit_tc;
   assign z_free       = ~z_valid_q | z_ready;
   assign release_full = (state_q == ST_FULL) & z_ready;
   assign load         = (frame_done & z_free) | release_full;
   assign ones_inc     = ones_q + {{OUT_WIDTH{1'b0}}, sn_in};
   assign load_val     = release_full ? ones_q : ones_inc;

   frame_counter #(.WIDTH(OUT_WIDTH)) u_frame_counter (
      .clk (clk),
      .rst (rst),
      .clr (restart),
      .en  (count_bit),
      .cnt (bit_cnt),
      .tc  (bit_tc)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start && en) state_d = ST_COUNT;
         ST_COUNT: if (frame_done) state_d = !z_free ? ST_FULL : (cont ? ST_COUNT : ST_IDLE);
         ST_FULL:  if (z_ready) state_d = cont ? ST_COUNT : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sn_ready = 1'b0;
      busy     = 1'b0;
      case (state_q)
         ST_COUNT: begin
            sn_ready = 1'b1;
            busy     = 1'b1;
         end
         ST_FULL:  busy = 1'b1;
         default:  ;
      endcase
   end

   // A finished frame that cannot load keeps its count in ones_q until released.
   always_comb begin
      ones_d    = ones_q;
      z_d       = z_q;
      z_sat_d   = z_sat_q;
      z_valid_d = z_valid_q;
      if (restart || load) begin
         ones_d = '0;
      end else if (count_bit) begin
         ones_d = ones_inc;
      end
      if (load) begin
         z_valid_d = 1'b1;
         z_sat_d   = load_val[OUT_WIDTH];
         z_d       = load_val[OUT_WIDTH] ? '1 : load_val[OUT_WIDTH-1:0];
      end else if (z_ready) begin
         z_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ones_q    <= '0;
         z_q       <= '0;
         z_sat_q   <= 1'b0;
         z_valid_q <= 1'b0;
      end else begin
         ones_q    <= ones_d;
         z_q       <= z_d;
         z_sat_q   <= z_sat_d;
         z_valid_q <= z_valid_d;
      end
   end

   assign z       = z_q;
   assign z_sat   = z_sat_q;
   assign z_valid = z_valid_q;

endmodule

// File: tb/tb_dsc_stream_decoder.sv
// Self-checking bench for dsc_stream_decoder (OUT_WIDTH=4, 16-bit frames):
// frame-level reference model feeds a result scoreboard drained by a monitor.
module tb_dsc_stream_decoder;

   localparam int W = 4;
   localparam int N = 16;

   typedef struct packed {
      logic [W-1:0] z;
      logic         sat;
   } res_t;

   logic         clk;
   logic         rst, en, start, cont, sn_in, sn_valid, z_ready;
   logic         sn_ready, z_valid, z_sat, busy;
   logic [W-1:0] z;

   int   n_checks = 0;
   int   n_fail   = 0;
   res_t exp_q[$];

   // Reference model state: counting, stalled, bits/ones in the frame, results not yet consumed.
   bit   m_active = 0;
   bit   m_full   = 0;
   int   m_bits   = 0;
   int   m_ones   = 0;
   int   m_occ    = 0;

   dsc_stream_decoder #(.SNG_WIDTH(2), .NUM_INPUTS(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .start    (start),
      .cont     (cont),
      .sn_in    (sn_in),
      .sn_valid (sn_valid),
      .sn_ready (sn_ready),
      .z        (z),
      .z_valid  (z_valid),
      .z_ready  (z_ready),
      .z_sat    (z_sat),
      .busy     (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame-level model: evaluated on the falling edge with the inputs the next rising edge will see.
   always @(negedge clk) begin
      bit consume, blocked;
      res_t r;
      check("sn_ready", sn_ready, m_active);
      check("busy", busy, m_active || m_full);
      check("z_valid", z_valid, m_occ > 0);
      if (!rst) begin
         m_active = 0; m_full = 0; m_bits = 0; m_ones = 0; m_occ = 0;
         exp_q.delete();
      end else begin
         consume = (m_occ > 0) && z_ready;
         blocked = (m_occ > 0) && !z_ready;
         if (m_full) begin
            if (z_ready) begin
               m_full   = 0;
               m_active = cont;
            end
         end else if (m_active && en && start) begin
            m_bits = 0;
            m_ones = 0;
         end else if (m_active && en && sn_valid) begin
            m_bits++;
            m_ones += int'(sn_in);
            if (m_bits == N) begin
               r.sat = (m_ones == N);
               r.z   = r.sat ? W'(N - 1) : W'(m_ones);
               exp_q.push_back(r);
               m_occ++;
               m_bits = 0;
               m_ones = 0;
               if (blocked) begin
                  m_full   = 1;
                  m_active = 0;
               end else begin
                  m_active = cont;
               end
            end
         end else if (!m_active && en && start) begin
            m_active = 1;
            m_bits   = 0;
            m_ones   = 0;
         end
         if (consume) m_occ--;
      end
   end

   // Monitor: every result handshake pops the next expected frame count.
   always @(negedge clk) begin
      res_t e;
      if (rst && z_valid && z_ready) begin
         check("result_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("z", z, e.z);
            check("z_sat", z_sat, e.sat);
         end
      end
   end

   task automatic drive(input logic e, s, c, v, b, zr, input int n = 1);
      en = e; start = s; cont = c; sn_valid = v; sn_in = b; z_ready = zr;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [N-1:0] pat, input logic c, zr);
      for (int i = 0; i < N; i++) drive(1, 0, c, 1, pat[i], zr);
   endtask

   function automatic logic [N-1:0] pattern(input int k);
      logic [N-1:0] p = '0;
      while ($countones(p) < k) p[$urandom_range(N - 1)] = 1'b1;
      return p;
   endfunction

   initial begin
      logic [N-1:0] pat;
      int p_one;

      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         en = 1'($urandom); start = 1'($urandom); cont = 1'($urandom);
         sn_valid = 1'($urandom); sn_in = 1'($urandom); z_ready = 1'($urandom);
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      en = 0; start = 0; cont = 0; sn_valid = 0; sn_in = 0; z_ready = 0;
      #1;
      check("reset_z", z, 0);
      check("reset_z_valid", z_valid, 0);
      check("reset_z_sat", z_sat, 0);
      check("reset_sn_ready", sn_ready, 0);
      check("reset_busy", busy, 0);
      drive(1, 0, 0, 0, 0, 0, 2);

      // Single frame with five ones.
      drive(1, 1, 0, 0, 0, 1);
      send_bits(pattern(5), 0, 1);
      check("single_z_valid", z_valid, 1);
      check("single_z", z, 5);
      check("single_z_sat", z_sat, 0);
      drive(1, 0, 0, 0, 0, 1, 3);
      check("single_idle", busy, 0);

      // All-ones frame saturates.
      drive(1, 1, 0, 0, 0, 1);
      send_bits({N{1'b1}}, 0, 1);
      check("sat_z", z, 15);
      check("sat_z_sat", z_sat, 1);
      drive(1, 0, 0, 0, 0, 1, 3);

      // Backpressure: two frames back to back with the consumer stalled.
      drive(1, 1, 1, 0, 0, 0);
      send_bits(pattern(5), 1, 0);
      send_bits(pattern(3), 1, 0);
      check("bp_sn_ready_low", sn_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_hold_z", z, 5);
      drive(1, 0, 1, 1, 1'($urandom), 0, 3);
      check("bp_stable_z", z, 5);
      drive(1, 0, 0, 0, 0, 1);
      check("bp_second_z", z, 3);
      check("bp_second_valid", z_valid, 1);
      drive(1, 0, 0, 0, 0, 0, 2);
      drive(1, 0, 0, 0, 0, 1);
      check("bp_drained", z_valid, 0);
      check("bp_idle", busy, 0);

      // Gaps: idle-valid and disabled cycles woven into a seven-ones frame.
      drive(1, 1, 0, 0, 0, 1);
      pat = pattern(7);
      for (int i = 0; i < N; i++) begin
         for (int g = $urandom_range(2); g > 0; g--) begin
            if ($urandom_range(1) == 0) drive(1, 0, 0, 0, 1'($urandom), 1);
            else                        drive(0, 0, 0, 1, 1'($urandom), 1);
         end
         drive(1, 0, 0, 1, pat[i], 1);
      end
      check("gap_z", z, 7);
      drive(1, 0, 0, 0, 0, 1, 2);

      // Abort after nine bits; the bit on the restart cycle is dropped.
      drive(1, 1, 0, 0, 0, 1);
      for (int i = 0; i < 9; i++) drive(1, 0, 0, 1, 1'($urandom), 1);
      drive(1, 1, 0, 1, 1, 1);
      send_bits(pattern(4), 0, 1);
      check("abort_z", z, 4);
      drive(1, 0, 0, 0, 0, 1, 2);

      // Reset in the middle of a frame.
      drive(1, 1, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) drive(1, 0, 0, 1, 1, 1);
      rst = 1'b0;
      drive(1, 0, 0, 1, 1, 1);
      rst = 1'b1;
      check("midrst_z_valid", z_valid, 0);
      check("midrst_busy", busy, 0);
      drive(1, 0, 0, 0, 0, 1, 20);
      check("midrst_no_result", z_valid, 0);

      // Randomized traffic with varying ones density.
      for (int seg = 0; seg < 15; seg++) begin
         p_one = (seg % 3) * 50;
         for (int i = 0; i < 200; i++) begin
            rst = ($urandom_range(299) != 0);
            drive($urandom_range(9) != 0, $urandom_range(39) == 0, 1'($urandom),
                  $urandom_range(3) != 0, $urandom_range(99) < p_one, $urandom_range(2) != 0);
         end
      end
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 1, 40);
      check("drain_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
